// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - multi-cycle wide adder, one DATA_WIDTH chunk per clock
// Operands are latched on acceptance; the result register fills chunk by chunk.
module wide_add_seq #(
    parameter  int DATA_WIDTH  = 8,
    parameter  int NUM_CHUNKS  = 4,
    localparam int TOTAL_WIDTH = DATA_WIDTH * NUM_CHUNKS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TOTAL_WIDTH-1:0] a,
    input  logic [TOTAL_WIDTH-1:0] b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TOTAL_WIDTH-1:0] sum,
    output logic                   cout,
    output logic                   busy
);

    localparam int IDX_W = $clog2(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [TOTAL_WIDTH-1:0] r_a;
    logic [TOTAL_WIDTH-1:0] r_b;
    logic [TOTAL_WIDTH-1:0] r_sum;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_carry;
    logic                   r_cout;
    logic                   r_out_valid;
    logic                   r_in_ready;
    logic                   r_busy;

    logic [DATA_WIDTH-1:0]  w_a_chunk;
    logic [DATA_WIDTH-1:0]  w_b_chunk;
    logic [DATA_WIDTH-1:0]  w_g;
    logic [DATA_WIDTH-1:0]  w_p;
    logic [DATA_WIDTH-1:0]  w_s_chunk;
    logic                   w_chunk_cout;

    // Select the active chunk and ripple the carry through it combinationally.
    always_comb begin
        logic v_c;
        w_a_chunk = DATA_WIDTH'(r_a >> (DATA_WIDTH * int'(r_idx)));
        w_b_chunk = DATA_WIDTH'(r_b >> (DATA_WIDTH * int'(r_idx)));
        w_g       = w_a_chunk & w_b_chunk;
        w_p       = w_a_chunk | w_b_chunk;
        w_s_chunk = '0;
        v_c       = r_carry;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_s_chunk[i] = w_a_chunk[i] ^ w_b_chunk[i] ^ v_c;
            v_c          = w_g[i] | (w_p[i] & v_c);
        end
        w_chunk_cout = v_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_carry    <= cin;
                        r_idx      <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    r_sum[DATA_WIDTH * int'(r_idx) +: DATA_WIDTH] <= w_s_chunk;
                    r_carry <= w_chunk_cout;
                    // Index parks on the last chunk; it is cleared on the next accept.
                    if (r_idx == LAST_IDX) begin
                        r_state     <= DONE;
                        r_cout      <= w_chunk_cout;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign busy      = r_busy;

endmodule

// File: tb/tb_wide_add_seq.sv
// tb/tb_wide_add_seq.sv - self-checking bench for wide_add_seq
// Directed cases with literal results plus randomized traffic against a cycle-level model.
module tb_wide_add_seq;

    localparam int DW = 8;
    localparam int NC = 4;
    localparam int TW = DW * NC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [TW-1:0] a = '0;
    logic [TW-1:0] b = '0;
    logic          cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [TW-1:0] sum;
    logic          cout;
    logic          busy;

    int checks = 0;
    int errors = 0;

    wide_add_seq #(.DATA_WIDTH(DW), .NUM_CHUNKS(NC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: tracks only "busy", cycles since acceptance and the integer result.
    logic          m_busy = 1'b0;
    int            m_cnt = 0;
    logic [TW:0]   m_res = '0;
    logic [TW-1:0] m_sum_vis = '0;
    int            m_accepts = 0;
    int            m_retired = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy    = 1'b0;
            m_cnt     = 0;
            m_res     = '0;
            m_sum_vis = '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_res  = {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, cin};
                m_accepts++;
            end
        end else if (m_cnt < NC) begin
            m_cnt++;
            if (m_cnt == NC) m_sum_vis = m_res[TW-1:0];
        end else if (out_ready) begin
            m_busy = 1'b0;
            m_retired++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        chk("busy", 64'(busy), 64'(m_busy));
        chk("in_ready", 64'(in_ready), 64'(!m_busy));
        chk("out_valid", 64'(out_valid), 64'(m_busy && m_cnt == NC));
        if (m_busy && m_cnt == NC)
            chk("result", 64'({cout, sum}), 64'(m_res));
        else if (!m_busy)
            chk("sum_idle", 64'(sum), 64'(m_sum_vis));
    endtask

    task automatic run_op(input logic [TW-1:0] ta, input logic [TW-1:0] tb_,
                          input logic tc, input logic [TW-1:0] exp_sum,
                          input logic exp_cout, input int stall, input string name);
        int lat;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a = ~ta; b = ~tb_; cin = ~tc;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(NC));
        chk({name, "_sum"}, 64'(sum), 64'(exp_sum));
        chk({name, "_cout"}, 64'(cout), 64'(exp_cout));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({name, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({name, "_hold_ready"}, 64'(in_ready), 64'd0);
            chk({name, "_hold_sum"}, 64'(sum), 64'(exp_sum));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_retired"}, 64'(out_valid), 64'd0);
        chk({name, "_sum_kept"}, 64'(sum), 64'(exp_sum));
    endtask

    initial begin
        int acc0;
        int cyc;
        repeat (2) @(negedge clk);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 0, "ripple");
        run_op(32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 0, "cin_only");
        run_op(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 0, "msb_carry");
        run_op(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 6, "backpressure");

        // Reset sampled at the second RUN edge.
        @(negedge clk);
        a = 32'hDEADBEEF; b = 32'h01010101; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_rst_sum", 64'(sum), 64'd0);
        chk("midrun_rst_valid", 64'(out_valid), 64'd0);
        chk("midrun_rst_ready", 64'(in_ready), 64'd1);
        repeat (8) begin
            @(negedge clk);
            chk("midrun_no_valid", 64'(out_valid), 64'd0);
        end
        run_op(32'hDEADBEEF, 32'h01010101, 1'b1, 32'hDFAEBFF1, 1'b0, 1, "after_rst");

        // Back-to-back: in_valid and out_ready held high, operands churn every cycle.
        @(negedge clk);
        acc0 = m_accepts;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10 * (NC + 2); i++) begin
            a = TW'($urandom); b = TW'($urandom); cin = 1'($urandom);
            @(negedge clk);
        end
        chk("b2b_accepts", 64'(m_accepts - acc0), 64'd10);
        in_valid = 1'b0; out_ready = 1'b0;

        // Random stalls on both sides.
        acc0 = m_retired;
        cyc = 0;
        while (m_retired - acc0 < 2000 && cyc < 60000) begin
            a = TW'($urandom); b = TW'($urandom); cin = 1'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            cyc++;
        end
        chk("random_completed", 64'(m_retired - acc0 >= 2000), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
